// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode/funct values, controller state encodings and instruction classes
package cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5
   } state_t;

   localparam logic [3:0] C_NOP   = 4'd0;
   localparam logic [3:0] C_RTYPE = 4'd1;
   localparam logic [3:0] C_JR    = 4'd2;
   localparam logic [3:0] C_LW    = 4'd3;
   localparam logic [3:0] C_SW    = 4'd4;
   localparam logic [3:0] C_BR    = 4'd5;
   localparam logic [3:0] C_J     = 4'd6;
   localparam logic [3:0] C_JAL   = 4'd7;
   localparam logic [3:0] C_IALU  = 4'd8;
   localparam logic [3:0] C_ILL   = 4'd9;

endpackage

// File: rtl/instr_classify.sv
// instr_classify: combinational opcode/funct to instruction-class map
module instr_classify
   import cpu_pkg::*;
(
   input  logic [5:0] op_i,
   input  logic [5:0] funct_i,
   output logic [3:0] cls_o
);

   assign cls_o = (op_i == OP_RTYPE)                  ? ((funct_i == FN_JR) ? C_JR : C_RTYPE) :
                  (op_i == OP_LW)                     ? C_LW :
                  (op_i == OP_SW)                     ? C_SW :
                  (op_i == OP_BEQ || op_i == OP_BNE)  ? C_BR :
                  (op_i == OP_J)                      ? C_J :
                  (op_i == OP_JAL)                    ? C_JAL :
                  (op_i[5:3] == 3'b001)               ? C_IALU : C_ILL;

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IDLE/FETCH/DECODE/EXEC/MEM/WB sequencer with mem-ack timeout
// and retired-instruction counter
module multicycle_ctrl
   import cpu_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             run,
   input  logic [31:0]      Instruction,
   input  logic             mem_ack,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             Branch,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             ALUSrc,
   output logic             RegWrite,
   output logic             MemtoReg,
   output logic             RegDst,
   output logic             Jal,
   output logic             illegal,
   output logic             bus_err,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired
);

   localparam int TW = $clog2(MEM_TIMEOUT + 1);

   state_t           state_q, state_d;
   logic [3:0]       cls_q, cls_d, cls_live, cls;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             fin, tmo_hit;
   logic             unused_instr;

   assign unused_instr = ^Instruction[25:6];

   instr_classify u_cls (
      .op_i    (Instruction[31:26]),
      .funct_i (Instruction[5:0]),
      .cls_o   (cls_live)
   );

   // DECODE must act on the IR in the same cycle it is latched
   assign cls     = (state_q == S_DECODE) ? cls_live : cls_q;
   assign cls_d   = cls;
   assign tmo_hit = (state_q == S_MEM) && !mem_ack && (tmo_q == TW'(MEM_TIMEOUT - 1));
   assign tmo_d   = ((state_q == S_MEM) && !mem_ack && !tmo_hit) ? tmo_q + TW'(1) : '0;
   assign retired_d = retired_q + CNT_W'(fin);
   assign state   = state_q;
   assign retired = retired_q;

   always_comb begin
      state_d  = S_IDLE;
      fin      = 1'b0;
      IRWrite  = 1'b0;
      Branch   = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      ALUSrc   = 1'b0;
      RegWrite = 1'b0;
      MemtoReg = 1'b0;
      RegDst   = 1'b0;
      Jal      = 1'b0;
      illegal  = 1'b0;
      bus_err  = 1'b0;
      case (state_q)
         S_IDLE:   state_d = run ? S_FETCH : S_IDLE;
         S_FETCH: begin
            IRWrite = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            fin     = (cls == C_J) || (cls == C_ILL);
            illegal = cls == C_ILL;
            state_d = (cls == C_JAL) ? S_WB : S_EXEC;
         end
         S_EXEC: begin
            ALUSrc  = (cls == C_IALU) || (cls == C_LW) || (cls == C_SW);
            Branch  = cls == C_BR;
            fin     = (cls == C_BR) || (cls == C_JR);
            state_d = ((cls == C_LW) || (cls == C_SW)) ? S_MEM : S_WB;
         end
         S_MEM: begin
            ALUSrc   = 1'b1;
            MemRead  = cls == C_LW;
            MemWrite = cls == C_SW;
            bus_err  = tmo_hit;
            fin      = tmo_hit || (mem_ack && (cls == C_SW));
            state_d  = (mem_ack && (cls == C_LW)) ? S_WB : S_MEM;
         end
         S_WB: begin
            RegWrite = 1'b1;
            fin      = 1'b1;
            RegDst   = cls == C_RTYPE;
            MemtoReg = cls == C_LW;
            Jal      = cls == C_JAL;
         end
         default:  state_d = S_IDLE;
      endcase
      if (fin) state_d = run ? S_FETCH : S_IDLE;
   end

   assign PCWrite = fin;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cls_q     <= C_NOP;
         tmo_q     <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         tmo_q     <= tmo_d;
         retired_q <= retired_d;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed plus randomized instruction stream checked cycle by cycle
// against a latency/role model of each instruction class
module tb_multicycle_ctrl;

   localparam int TMO = 16;
   localparam int CW  = 4;
   localparam int K_R = 0, K_JR = 1, K_LW = 2, K_SW = 3, K_BR = 4,
                  K_J = 5, K_JAL = 6, K_IALU = 7, K_ILL = 8;

   logic          clock = 1'b0, reset = 1'b1, run = 1'b0, mem_ack = 1'b0;
   logic [31:0]   Instruction = '0;
   logic          IRWrite, PCWrite, Branch, MemRead, MemWrite, ALUSrc;
   logic          RegWrite, MemtoReg, RegDst, Jal, illegal, bus_err;
   logic [2:0]    state;
   logic [CW-1:0] retired;
   logic [CW-1:0] exp_ret;
   int            errors = 0, checks = 0;

   multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .run(run), .Instruction(Instruction), .mem_ack(mem_ack),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch), .MemRead(MemRead),
      .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
      .RegDst(RegDst), .Jal(Jal), .illegal(illegal), .bus_err(bus_err),
      .state(state), .retired(retired)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [14:0] obs_vec();
      return {state, IRWrite, PCWrite, Branch, MemRead, MemWrite, ALUSrc,
              RegWrite, MemtoReg, RegDst, Jal, illegal, bus_err};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected per-cycle roles come from the class latency table: FETCH first,
   // PCWrite only on the last cycle, register write only in a WB cycle.
   task automatic do_instr(input logic [31:0] ins, input int k, input int waits, input bit run_last);
      int st[$];
      int n;
      bit tmo, last, wb, mem, ls;
      logic [14:0] exp;
      ls  = (k == K_LW) || (k == K_SW);
      tmo = ls && (waits >= TMO);
      n   = tmo ? TMO : waits + 1;
      st.push_back(1);
      st.push_back(2);
      if (k == K_JAL) st.push_back(5);
      else if (k != K_J && k != K_ILL) begin
         st.push_back(3);
         if (ls) repeat (n) st.push_back(4);
         if (k == K_R || k == K_IALU || (k == K_LW && !tmo)) st.push_back(5);
      end
      for (int i = 0; i < st.size(); i++) begin
         last = (i == st.size() - 1);
         wb   = (st[i] == 5);
         mem  = (st[i] == 4);
         @(negedge clock);
         Instruction = ins;
         mem_ack = mem ? ((i - 3) == waits) : 1'($urandom % 2);
         run     = last ? run_last : 1'($urandom % 2);
         #1;
         exp = {3'(st[i]), i == 0, last, last && k == K_BR, mem && k == K_LW, mem && k == K_SW,
                (st[i] == 3 && (k == K_IALU || ls)) || mem, wb, wb && k == K_LW,
                wb && k == K_R, wb && k == K_JAL, last && k == K_ILL, last && tmo};
         chk($sformatf("ctrl k%0d c%0d", k, i), 32'(obs_vec()), 32'(exp));
         chk("retired", 32'(retired), 32'(exp_ret));
         if (last) exp_ret++;
      end
   endtask

   task automatic rand_instr(output logic [31:0] ins, output int k);
      logic [5:0] ill_ops [5];
      logic [5:0] fn;
      ill_ops = '{6'h01, 6'h06, 6'h10, 6'h20, 6'h3F};
      k   = int'($urandom_range(0, 8));
      ins = $urandom;
      fn  = ins[5:0];
      case (k)
         K_R:     ins = {6'h00, ins[25:6], (fn == 6'h08) ? 6'h20 : fn};
         K_JR:    ins = {6'h00, ins[25:6], 6'h08};
         K_LW:    ins = {6'h23, ins[25:0]};
         K_SW:    ins = {6'h2B, ins[25:0]};
         K_BR:    ins = {5'b00010, ins[26], ins[25:0]};
         K_J:     ins = {6'h02, ins[25:0]};
         K_JAL:   ins = {6'h03, ins[25:0]};
         K_IALU:  ins = {3'b001, ins[28:0]};
         default: ins = {ill_ops[$urandom_range(0, 4)], ins[25:0]};
      endcase
   endtask

   initial begin
      logic [31:0] ins;
      int k, w;
      exp_ret = '0;
      @(negedge clock);
      #1;
      chk("reset ctrl", 32'(obs_vec()), 32'd0);
      chk("reset retired", 32'(retired), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      run   = 1'b1;
      #1;
      chk("idle ctrl", 32'(obs_vec()), 32'd0);
      do_instr(32'h00221820, K_R, 0, 1'b1);
      do_instr(32'h8C040008, K_LW, 2, 1'b1);
      do_instr(32'hAC050004, K_SW, 100, 1'b1);
      do_instr(32'h0C000010, K_JAL, 0, 1'b1);
      do_instr(32'hFC000000, K_ILL, 0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         rand_instr(ins, k);
         w = ($urandom % 5 == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 3));
         do_instr(ins, k, w, 1'b1);
      end
      do_instr(32'h10220003, K_BR, 0, 1'b0);
      @(negedge clock);
      run = 1'b0;
      #1;
      chk("beq then idle", 32'(obs_vec()), 32'd0);
      chk("retired wrap", 32'(retired), 32'd0);
      run = 1'b1;
      Instruction = 32'h8C040008;
      mem_ack = 1'b0;
      repeat (5) @(negedge clock);
      run = 1'b0;
      #1;
      chk("mem2 lw", 32'(obs_vec()), {17'd0, 3'd4, 12'b000101000000});
      reset = 1'b1;
      #1;
      chk("async reset ctrl", 32'(obs_vec()), 32'd0);
      chk("async reset retired", 32'(retired), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         #1;
         chk("idle hold", 32'(obs_vec()), 32'd0);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
